// File: rtl/axi_addr_router_if.sv
// AXI4 bus bundle shared by the upstream arbiter port and both downstream slave ports.
// The master modport drives requests; the slave modport drives responses.
interface axi_if #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
);
  logic [IdWidth-1:0]     awid;
  logic [AddrWidth-1:0]   awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;

  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [IdWidth-1:0]     bid;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  logic [IdWidth-1:0]     arid;
  logic [AddrWidth-1:0]   araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;

  logic [IdWidth-1:0]     rid;
  logic [DataWidth-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_addr_router.sv
// 1-to-2 AXI4 address router with independent read/write transaction locks and an
// internal DECERR responder for unmapped addresses.
module axi_addr_router #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hF000_0000,
  parameter logic [31:0] S1_BASE = 32'h1000_0000,
  parameter logic [31:0] S1_MASK = 32'hF000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  axi_if.slave       s_axi,
  axi_if.master      m_axi_0,
  axi_if.master      m_axi_1,
  output logic [1:0] debug_rd_state,
  output logic [1:0] debug_wr_state
);

  typedef enum logic [1:0] {RdIdle = 2'd0, RdData = 2'd1, RdErr = 2'd2} rd_state_e;
  typedef enum logic [1:0] {WrIdle = 2'd0, WrData = 2'd1, WrResp = 2'd2, WrErr = 2'd3} wr_state_e;

  rd_state_e  rd_state_q;
  logic       rd_tgt_q;
  logic [3:0] rd_id_q;
  logic [7:0] rd_len_q;
  logic [7:0] rd_cnt_q;

  wr_state_e  wr_state_q;
  logic       wr_tgt_q;
  logic [3:0] wr_id_q;
  logic       wr_resp_q;  // DECERR write: 0 = sinking W beats, 1 = presenting B

  logic ar_sel0, ar_sel1, ar_err;
  logic aw_sel0, aw_sel1, aw_err;

  // Slave 0 wins when both regions match.
  assign ar_sel0 = (s_axi.araddr & S0_MASK) == S0_BASE;
  assign ar_sel1 = !ar_sel0 && ((s_axi.araddr & S1_MASK) == S1_BASE);
  assign ar_err  = !ar_sel0 && !ar_sel1;
  assign aw_sel0 = (s_axi.awaddr & S0_MASK) == S0_BASE;
  assign aw_sel1 = !aw_sel0 && ((s_axi.awaddr & S1_MASK) == S1_BASE);
  assign aw_err  = !aw_sel0 && !aw_sel1;

  assign debug_rd_state = rd_state_q;
  assign debug_wr_state = wr_state_q;

  always_comb begin
    m_axi_0.awid = '0; m_axi_0.awaddr = '0; m_axi_0.awlen = '0; m_axi_0.awsize = '0;
    m_axi_0.awburst = '0; m_axi_0.awvalid = 1'b0;
    m_axi_0.wdata = '0; m_axi_0.wstrb = '0; m_axi_0.wlast = 1'b0; m_axi_0.wvalid = 1'b0;
    m_axi_0.bready = 1'b0;
    m_axi_0.arid = '0; m_axi_0.araddr = '0; m_axi_0.arlen = '0; m_axi_0.arsize = '0;
    m_axi_0.arburst = '0; m_axi_0.arvalid = 1'b0;
    m_axi_0.rready = 1'b0;

    m_axi_1.awid = '0; m_axi_1.awaddr = '0; m_axi_1.awlen = '0; m_axi_1.awsize = '0;
    m_axi_1.awburst = '0; m_axi_1.awvalid = 1'b0;
    m_axi_1.wdata = '0; m_axi_1.wstrb = '0; m_axi_1.wlast = 1'b0; m_axi_1.wvalid = 1'b0;
    m_axi_1.bready = 1'b0;
    m_axi_1.arid = '0; m_axi_1.araddr = '0; m_axi_1.arlen = '0; m_axi_1.arsize = '0;
    m_axi_1.arburst = '0; m_axi_1.arvalid = 1'b0;
    m_axi_1.rready = 1'b0;

    s_axi.awready = 1'b0; s_axi.wready = 1'b0;
    s_axi.bid = '0; s_axi.bresp = '0; s_axi.bvalid = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.rid = '0; s_axi.rdata = '0; s_axi.rresp = '0; s_axi.rlast = 1'b0; s_axi.rvalid = 1'b0;

    unique case (rd_state_q)
      RdIdle: begin
        if (ar_sel0) begin
          if (s_axi.arvalid) begin
            m_axi_0.arvalid = 1'b1;           m_axi_0.arid   = s_axi.arid;
            m_axi_0.araddr  = s_axi.araddr;   m_axi_0.arlen  = s_axi.arlen;
            m_axi_0.arsize  = s_axi.arsize;   m_axi_0.arburst = s_axi.arburst;
          end
          s_axi.arready = m_axi_0.arready;
        end else if (ar_sel1) begin
          if (s_axi.arvalid) begin
            m_axi_1.arvalid = 1'b1;           m_axi_1.arid   = s_axi.arid;
            m_axi_1.araddr  = s_axi.araddr;   m_axi_1.arlen  = s_axi.arlen;
            m_axi_1.arsize  = s_axi.arsize;   m_axi_1.arburst = s_axi.arburst;
          end
          s_axi.arready = m_axi_1.arready;
        end else begin
          s_axi.arready = 1'b1;
        end
      end
      RdData: begin
        if (!rd_tgt_q) begin
          s_axi.rvalid = m_axi_0.rvalid; s_axi.rid   = m_axi_0.rid;   s_axi.rdata = m_axi_0.rdata;
          s_axi.rresp  = m_axi_0.rresp;  s_axi.rlast = m_axi_0.rlast; m_axi_0.rready = s_axi.rready;
        end else begin
          s_axi.rvalid = m_axi_1.rvalid; s_axi.rid   = m_axi_1.rid;   s_axi.rdata = m_axi_1.rdata;
          s_axi.rresp  = m_axi_1.rresp;  s_axi.rlast = m_axi_1.rlast; m_axi_1.rready = s_axi.rready;
        end
      end
      RdErr: begin
        s_axi.rvalid = 1'b1;
        s_axi.rresp  = 2'b11;
        s_axi.rid    = rd_id_q;
        s_axi.rlast  = (rd_cnt_q == rd_len_q);
      end
      default: ;
    endcase

    unique case (wr_state_q)
      WrIdle: begin
        if (aw_sel0) begin
          if (s_axi.awvalid) begin
            m_axi_0.awvalid = 1'b1;           m_axi_0.awid   = s_axi.awid;
            m_axi_0.awaddr  = s_axi.awaddr;   m_axi_0.awlen  = s_axi.awlen;
            m_axi_0.awsize  = s_axi.awsize;   m_axi_0.awburst = s_axi.awburst;
          end
          s_axi.awready = m_axi_0.awready;
        end else if (aw_sel1) begin
          if (s_axi.awvalid) begin
            m_axi_1.awvalid = 1'b1;           m_axi_1.awid   = s_axi.awid;
            m_axi_1.awaddr  = s_axi.awaddr;   m_axi_1.awlen  = s_axi.awlen;
            m_axi_1.awsize  = s_axi.awsize;   m_axi_1.awburst = s_axi.awburst;
          end
          s_axi.awready = m_axi_1.awready;
        end else begin
          s_axi.awready = 1'b1;
        end
      end
      WrData: begin
        if (!wr_tgt_q) begin
          m_axi_0.wvalid = s_axi.wvalid; m_axi_0.wdata = s_axi.wdata;
          m_axi_0.wstrb  = s_axi.wstrb;  m_axi_0.wlast = s_axi.wlast;
          s_axi.wready   = m_axi_0.wready;
        end else begin
          m_axi_1.wvalid = s_axi.wvalid; m_axi_1.wdata = s_axi.wdata;
          m_axi_1.wstrb  = s_axi.wstrb;  m_axi_1.wlast = s_axi.wlast;
          s_axi.wready   = m_axi_1.wready;
        end
      end
      WrResp: begin
        if (!wr_tgt_q) begin
          s_axi.bvalid = m_axi_0.bvalid; s_axi.bid = m_axi_0.bid; s_axi.bresp = m_axi_0.bresp;
          m_axi_0.bready = s_axi.bready;
        end else begin
          s_axi.bvalid = m_axi_1.bvalid; s_axi.bid = m_axi_1.bid; s_axi.bresp = m_axi_1.bresp;
          m_axi_1.bready = s_axi.bready;
        end
      end
      WrErr: begin
        if (!wr_resp_q) begin
          s_axi.wready = 1'b1;
        end else begin
          s_axi.bvalid = 1'b1;
          s_axi.bresp  = 2'b11;
          s_axi.bid    = wr_id_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q <= RdIdle;
      rd_tgt_q   <= 1'b0;
      rd_id_q    <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      wr_state_q <= WrIdle;
      wr_tgt_q   <= 1'b0;
      wr_id_q    <= '0;
      wr_resp_q  <= 1'b0;
    end else begin
      unique case (rd_state_q)
        RdIdle: begin
          if (s_axi.arvalid && s_axi.arready) begin
            if (ar_err) begin
              rd_id_q    <= s_axi.arid;
              rd_len_q   <= s_axi.arlen;
              rd_cnt_q   <= '0;
              rd_state_q <= RdErr;
            end else begin
              rd_tgt_q   <= ar_sel1;
              rd_state_q <= RdData;
            end
          end
        end
        RdData: if (s_axi.rvalid && s_axi.rready && s_axi.rlast) rd_state_q <= RdIdle;
        RdErr: begin
          if (s_axi.rready) begin
            rd_cnt_q <= rd_cnt_q + 8'd1;
            if (rd_cnt_q == rd_len_q) rd_state_q <= RdIdle;
          end
        end
        default: rd_state_q <= RdIdle;
      endcase

      unique case (wr_state_q)
        WrIdle: begin
          if (s_axi.awvalid && s_axi.awready) begin
            if (aw_err) begin
              wr_id_q    <= s_axi.awid;
              wr_resp_q  <= 1'b0;
              wr_state_q <= WrErr;
            end else begin
              wr_tgt_q   <= aw_sel1;
              wr_state_q <= WrData;
            end
          end
        end
        WrData: if (s_axi.wvalid && s_axi.wready && s_axi.wlast) wr_state_q <= WrResp;
        WrResp: if (s_axi.bvalid && s_axi.bready) wr_state_q <= WrIdle;
        WrErr: begin
          if (!wr_resp_q) begin
            if (s_axi.wvalid && s_axi.wlast) wr_resp_q <= 1'b1;
          end else if (s_axi.bready) begin
            wr_resp_q  <= 1'b0;
            wr_state_q <= WrIdle;
          end
        end
        default: wr_state_q <= WrIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_addr_router.sv
// Directed bench for axi_addr_router: routing, DECERR responder, concurrency, stall and reset.
module tb_axi_addr_router;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] debug_rd_state;
  logic [1:0] debug_wr_state;
  int         n_pass = 0;
  int         n_total = 0;

  axi_if s_bus ();
  axi_if m0_bus ();
  axi_if m1_bus ();

  axi_addr_router dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axi          (s_bus),
    .m_axi_0        (m0_bus),
    .m_axi_1        (m1_bus),
    .debug_rd_state (debug_rd_state),
    .debug_wr_state (debug_wr_state)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    s_bus.awid = '0; s_bus.awaddr = '0; s_bus.awlen = '0; s_bus.awsize = 3'd2;
    s_bus.awburst = 2'd1; s_bus.awvalid = 1'b0;
    s_bus.wdata = '0; s_bus.wstrb = '0; s_bus.wlast = 1'b0; s_bus.wvalid = 1'b0;
    s_bus.bready = 1'b0;
    s_bus.arid = '0; s_bus.araddr = '0; s_bus.arlen = '0; s_bus.arsize = 3'd2;
    s_bus.arburst = 2'd1; s_bus.arvalid = 1'b0;
    s_bus.rready = 1'b0;
    m0_bus.awready = 1'b0; m0_bus.wready = 1'b0; m0_bus.bid = '0; m0_bus.bresp = '0;
    m0_bus.bvalid = 1'b0; m0_bus.arready = 1'b0; m0_bus.rid = '0; m0_bus.rdata = '0;
    m0_bus.rresp = '0; m0_bus.rlast = 1'b0; m0_bus.rvalid = 1'b0;
    m1_bus.awready = 1'b0; m1_bus.wready = 1'b0; m1_bus.bid = '0; m1_bus.bresp = '0;
    m1_bus.bvalid = 1'b0; m1_bus.arready = 1'b0; m1_bus.rid = '0; m1_bus.rdata = '0;
    m1_bus.rresp = '0; m1_bus.rlast = 1'b0; m1_bus.rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if ({debug_rd_state, debug_wr_state} !== 4'h0)
      $display("FAIL reset_state: got rd=%0d wr=%0d exp 0/0", debug_rd_state, debug_wr_state);
    else n_pass++;
    n_total++;
    if ({s_bus.arready, s_bus.awready, s_bus.wready, s_bus.rvalid, s_bus.bvalid,
         m0_bus.arvalid, m0_bus.awvalid, m0_bus.rready, m1_bus.arvalid, m1_bus.awvalid} !== '0)
      $display("FAIL reset_handshakes: some valid/ready nonzero after reset");
    else n_pass++;
  endtask

  task automatic test_read_s0();
    @(negedge clk);
    s_bus.arvalid = 1'b1; s_bus.araddr = 32'h0000_0100; s_bus.arlen = 8'd3; s_bus.arid = 4'd2;
    m0_bus.arready = 1'b1;
    #1;
    n_total++;
    if ({m0_bus.arvalid, m0_bus.araddr, m0_bus.arlen, m0_bus.arid, s_bus.arready, m1_bus.arvalid}
        !== {1'b1, 32'h0000_0100, 8'd3, 4'd2, 1'b1, 1'b0})
      $display("FAIL rd_s0_ar: got m0v=%b addr=%h len=%0d id=%0d rdy=%b m1v=%b exp 1/100/3/2/1/0",
               m0_bus.arvalid, m0_bus.araddr, m0_bus.arlen, m0_bus.arid, s_bus.arready,
               m1_bus.arvalid);
    else n_pass++;
    @(negedge clk);
    s_bus.arvalid = 1'b0; m0_bus.arready = 1'b0;
    s_bus.rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_bus.rvalid = 1'b1; m0_bus.rid = 4'd2; m0_bus.rdata = 32'hA000_0000 + i;
      m0_bus.rlast = (i == 3);
      #1;
      n_total++;
      if ({s_bus.rvalid, s_bus.rid, s_bus.rdata, s_bus.rlast, s_bus.rresp, m0_bus.rready}
          !== {1'b1, 4'd2, 32'hA000_0000 + i, (i == 3), 2'b00, 1'b1})
        $display("FAIL rd_s0_beat%0d: got v=%b id=%0d data=%h last=%b exp 1/2/%h/%b", i,
                 s_bus.rvalid, s_bus.rid, s_bus.rdata, s_bus.rlast, 32'hA000_0000 + i, i == 3);
      else n_pass++;
      n_total++;
      if ({m1_bus.arvalid, m1_bus.araddr, m1_bus.arid, m1_bus.rready, m1_bus.awvalid,
           m1_bus.wvalid, m1_bus.bready} !== '0)
        $display("FAIL rd_s0_m1_quiet: m1 outputs nonzero on beat %0d", i);
      else n_pass++;
      @(negedge clk);
    end
    m0_bus.rvalid = 1'b0; m0_bus.rlast = 1'b0; s_bus.rready = 1'b0;
    #1;
    n_total++;
    if (debug_rd_state !== 2'd0) $display("FAIL rd_s0_done: got %0d exp 0", debug_rd_state);
    else n_pass++;
  endtask

  task automatic test_write_s1();
    @(negedge clk);
    s_bus.awvalid = 1'b1; s_bus.awaddr = 32'h1000_0004; s_bus.awid = 4'd3; s_bus.awlen = 8'd0;
    m1_bus.awready = 1'b1;
    #1;
    n_total++;
    if ({m1_bus.awvalid, m1_bus.awaddr, m1_bus.awid, s_bus.awready, m0_bus.awvalid}
        !== {1'b1, 32'h1000_0004, 4'd3, 1'b1, 1'b0})
      $display("FAIL wr_s1_aw: got m1v=%b addr=%h id=%0d rdy=%b m0v=%b exp 1/10000004/3/1/0",
               m1_bus.awvalid, m1_bus.awaddr, m1_bus.awid, s_bus.awready, m0_bus.awvalid);
    else n_pass++;
    @(negedge clk);
    s_bus.awvalid = 1'b0; m1_bus.awready = 1'b0;
    s_bus.wvalid = 1'b1; s_bus.wdata = 32'hDEAD_BEEF; s_bus.wstrb = 4'hF; s_bus.wlast = 1'b1;
    m1_bus.wready = 1'b1;
    #1;
    n_total++;
    if ({debug_wr_state, m1_bus.wvalid, m1_bus.wdata, m1_bus.wstrb, m1_bus.wlast, s_bus.wready,
         m0_bus.wvalid} !== {2'd1, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b0})
      $display("FAIL wr_s1_w: got st=%0d v=%b data=%h strb=%h rdy=%b exp 1/1/deadbeef/f/1",
               debug_wr_state, m1_bus.wvalid, m1_bus.wdata, m1_bus.wstrb, s_bus.wready);
    else n_pass++;
    @(negedge clk);
    s_bus.wvalid = 1'b0; s_bus.wlast = 1'b0; m1_bus.wready = 1'b0;
    m1_bus.bvalid = 1'b1; m1_bus.bid = 4'd3; m1_bus.bresp = 2'b00; s_bus.bready = 1'b1;
    #1;
    n_total++;
    if ({debug_wr_state, s_bus.bvalid, s_bus.bid, s_bus.bresp, m1_bus.bready}
        !== {2'd2, 1'b1, 4'd3, 2'b00, 1'b1})
      $display("FAIL wr_s1_b: got st=%0d v=%b id=%0d resp=%0d rdy=%b exp 2/1/3/0/1",
               debug_wr_state, s_bus.bvalid, s_bus.bid, s_bus.bresp, m1_bus.bready);
    else n_pass++;
    @(negedge clk);
    m1_bus.bvalid = 1'b0; s_bus.bready = 1'b0;
    #1;
    n_total++;
    if (debug_wr_state !== 2'd0) $display("FAIL wr_s1_idle: got %0d exp 0", debug_wr_state);
    else n_pass++;
  endtask

  task automatic test_read_decerr();
    @(negedge clk);
    s_bus.arvalid = 1'b1; s_bus.araddr = 32'h8000_0000; s_bus.arlen = 8'd1; s_bus.arid = 4'd5;
    m0_bus.arready = 1'b1; m1_bus.arready = 1'b1;
    #1;
    n_total++;
    if ({m0_bus.arvalid, m1_bus.arvalid, s_bus.arready} !== 3'b001)
      $display("FAIL rd_err_ar: got m0v=%b m1v=%b rdy=%b exp 0/0/1",
               m0_bus.arvalid, m1_bus.arvalid, s_bus.arready);
    else n_pass++;
    @(negedge clk);
    s_bus.arvalid = 1'b0; m0_bus.arready = 1'b0; m1_bus.arready = 1'b0;
    s_bus.rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_total++;
      if ({s_bus.rvalid, s_bus.rresp, s_bus.rdata, s_bus.rid, s_bus.rlast, m0_bus.rready,
           m1_bus.rready} !== {1'b1, 2'b11, 32'h0, 4'd5, (i == 1), 2'b00})
        $display("FAIL rd_err_beat%0d: got v=%b resp=%0d data=%h id=%0d last=%b exp 1/3/0/5/%b",
                 i, s_bus.rvalid, s_bus.rresp, s_bus.rdata, s_bus.rid, s_bus.rlast, i == 1);
      else n_pass++;
      @(negedge clk);
    end
    s_bus.rready = 1'b0;
    #1;
    n_total++;
    if ({debug_rd_state, s_bus.rvalid} !== 3'b000)
      $display("FAIL rd_err_done: got st=%0d v=%b exp 0/0", debug_rd_state, s_bus.rvalid);
    else n_pass++;
  endtask

  task automatic test_write_decerr();
    @(negedge clk);
    s_bus.awvalid = 1'b1; s_bus.awaddr = 32'h8000_0000; s_bus.awid = 4'd6; s_bus.awlen = 8'd2;
    #1;
    n_total++;
    if ({m0_bus.awvalid, m1_bus.awvalid, s_bus.awready} !== 3'b001)
      $display("FAIL wr_err_aw: got m0v=%b m1v=%b rdy=%b exp 0/0/1",
               m0_bus.awvalid, m1_bus.awvalid, s_bus.awready);
    else n_pass++;
    @(negedge clk);
    s_bus.awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_bus.wvalid = 1'b1; s_bus.wdata = 32'h100 + i; s_bus.wstrb = 4'hF; s_bus.wlast = (i == 2);
      #1;
      n_total++;
      if ({s_bus.wready, s_bus.bvalid, m0_bus.wvalid, m1_bus.wvalid, m0_bus.wdata, m1_bus.wdata}
          !== {1'b1, 3'b000, 64'h0})
        $display("FAIL wr_err_w%0d: got rdy=%b bv=%b m0v=%b m1v=%b exp 1/0/0/0", i,
                 s_bus.wready, s_bus.bvalid, m0_bus.wvalid, m1_bus.wvalid);
      else n_pass++;
      @(negedge clk);
    end
    s_bus.wvalid = 1'b0; s_bus.wlast = 1'b0; s_bus.bready = 1'b1;
    #1;
    n_total++;
    if ({s_bus.bvalid, s_bus.bresp, s_bus.bid, s_bus.wready, m0_bus.bready, m1_bus.bready}
        !== {1'b1, 2'b11, 4'd6, 3'b000})
      $display("FAIL wr_err_b: got v=%b resp=%0d id=%0d exp 1/3/6",
               s_bus.bvalid, s_bus.bresp, s_bus.bid);
    else n_pass++;
    @(negedge clk);
    s_bus.bready = 1'b0;
    #1;
    n_total++;
    if ({debug_wr_state, s_bus.bvalid} !== 3'b000)
      $display("FAIL wr_err_done: got st=%0d v=%b exp 0/0", debug_wr_state, s_bus.bvalid);
    else n_pass++;
  endtask

  task automatic test_concurrent_and_stall();
    @(negedge clk);
    s_bus.arvalid = 1'b1; s_bus.araddr = 32'h0000_0000; s_bus.arid = 4'd1; s_bus.arlen = 8'd0;
    s_bus.awvalid = 1'b1; s_bus.awaddr = 32'h1000_0000; s_bus.awid = 4'd4; s_bus.awlen = 8'd0;
    m0_bus.arready = 1'b1; m1_bus.awready = 1'b1;
    #1;
    n_total++;
    if ({s_bus.arready, s_bus.awready, m0_bus.arvalid, m1_bus.awvalid, m0_bus.awvalid,
         m1_bus.arvalid} !== 6'b111100)
      $display("FAIL conc_hs: got ar_rdy=%b aw_rdy=%b m0ar=%b m1aw=%b exp 1/1/1/1",
               s_bus.arready, s_bus.awready, m0_bus.arvalid, m1_bus.awvalid);
    else n_pass++;
    @(negedge clk);
    s_bus.awvalid = 1'b0; m1_bus.awready = 1'b0;
    s_bus.araddr = 32'h0000_0200; s_bus.arid = 4'd7;  // second AR, must stall
    s_bus.wvalid = 1'b1; s_bus.wdata = 32'h1234_5678; s_bus.wstrb = 4'h3; s_bus.wlast = 1'b1;
    m1_bus.wready = 1'b1;
    #1;
    n_total++;
    if ({s_bus.arready, m0_bus.arvalid, m0_bus.araddr, s_bus.wready, m1_bus.wvalid}
        !== {2'b00, 32'h0, 2'b11})
      $display("FAIL conc_stall: got ar_rdy=%b m0ar=%b addr=%h w_rdy=%b exp 0/0/0/1",
               s_bus.arready, m0_bus.arvalid, m0_bus.araddr, s_bus.wready);
    else n_pass++;
    @(negedge clk);
    s_bus.wvalid = 1'b0; s_bus.wlast = 1'b0; m1_bus.wready = 1'b0;
    m0_bus.rvalid = 1'b1; m0_bus.rid = 4'd1; m0_bus.rlast = 1'b1; m0_bus.rdata = 32'hCAFE;
    s_bus.rready = 1'b1;
    m1_bus.bvalid = 1'b1; m1_bus.bid = 4'd4; s_bus.bready = 1'b1;
    #1;
    n_total++;
    if ({s_bus.arready, s_bus.rvalid, s_bus.rlast, s_bus.rid, s_bus.bvalid, s_bus.bid}
        !== {1'b0, 2'b11, 4'd1, 1'b1, 4'd4})
      $display("FAIL conc_resp: got ar_rdy=%b rv=%b rl=%b rid=%0d bv=%b bid=%0d exp 0/1/1/1/1/4",
               s_bus.arready, s_bus.rvalid, s_bus.rlast, s_bus.rid, s_bus.bvalid, s_bus.bid);
    else n_pass++;
    @(negedge clk);
    m0_bus.rvalid = 1'b0; m0_bus.rlast = 1'b0; m1_bus.bvalid = 1'b0; s_bus.bready = 1'b0;
    #1;
    n_total++;
    if ({s_bus.arready, m0_bus.arvalid, m0_bus.araddr, m0_bus.arid, debug_wr_state}
        !== {2'b11, 32'h0000_0200, 4'd7, 2'd0})
      $display("FAIL conc_release: got ar_rdy=%b m0ar=%b addr=%h id=%0d wst=%0d exp 1/1/200/7/0",
               s_bus.arready, m0_bus.arvalid, m0_bus.araddr, m0_bus.arid, debug_wr_state);
    else n_pass++;
    @(negedge clk);
    s_bus.arvalid = 1'b0; m0_bus.arready = 1'b0;
    m0_bus.rvalid = 1'b1; m0_bus.rid = 4'd7; m0_bus.rlast = 1'b1;
    #1;
    n_total++;
    if ({s_bus.rvalid, s_bus.rid} !== {1'b1, 4'd7})
      $display("FAIL conc_rd2: got v=%b id=%0d exp 1/7", s_bus.rvalid, s_bus.rid);
    else n_pass++;
    @(negedge clk);
    clear_inputs();
    #1;
    n_total++;
    if (debug_rd_state !== 2'd0) $display("FAIL conc_idle: got %0d exp 0", debug_rd_state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    s_bus.arvalid = 1'b1; s_bus.araddr = 32'h0000_0040; s_bus.arlen = 8'd3; s_bus.arid = 4'd2;
    m0_bus.arready = 1'b1;
    @(negedge clk);
    s_bus.arvalid = 1'b0; m0_bus.arready = 1'b0;
    m0_bus.rvalid = 1'b1; m0_bus.rid = 4'd2; m0_bus.rdata = 32'h1; s_bus.rready = 1'b1;
    @(negedge clk);
    m0_bus.rdata = 32'h2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (debug_rd_state !== 2'd1) $display("FAIL rst_pre: got %0d exp 1", debug_rd_state);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    #1;
    n_total++;
    if ({debug_rd_state, debug_wr_state, s_bus.arready, s_bus.awready, s_bus.wready,
         s_bus.rvalid, s_bus.bvalid, m0_bus.arvalid, m0_bus.rready, m0_bus.awvalid,
         m0_bus.wvalid, m0_bus.bready, m1_bus.arvalid, m1_bus.rready} !== '0)
      $display("FAIL rst_abort: got rd=%0d wr=%0d rv=%b m0rr=%b exp all 0",
               debug_rd_state, debug_wr_state, s_bus.rvalid, m0_bus.rready);
    else n_pass++;
    s_bus.arvalid = 1'b1; s_bus.araddr = 32'h0000_0080; s_bus.arlen = 8'd0; s_bus.arid = 4'd9;
    m0_bus.arready = 1'b1;
    #1;
    n_total++;
    if ({m0_bus.arvalid, m0_bus.arid, s_bus.arready} !== {1'b1, 4'd9, 1'b1})
      $display("FAIL rst_fresh_ar: got v=%b id=%0d rdy=%b exp 1/9/1",
               m0_bus.arvalid, m0_bus.arid, s_bus.arready);
    else n_pass++;
    @(negedge clk);
    s_bus.arvalid = 1'b0; m0_bus.arready = 1'b0;
    m0_bus.rvalid = 1'b1; m0_bus.rid = 4'd9; m0_bus.rlast = 1'b1; m0_bus.rdata = 32'h55;
    s_bus.rready = 1'b1;
    #1;
    n_total++;
    if ({s_bus.rvalid, s_bus.rid, s_bus.rdata, s_bus.rlast} !== {1'b1, 4'd9, 32'h55, 1'b1})
      $display("FAIL rst_fresh_r: got v=%b id=%0d data=%h last=%b exp 1/9/55/1",
               s_bus.rvalid, s_bus.rid, s_bus.rdata, s_bus.rlast);
    else n_pass++;
    @(negedge clk);
    clear_inputs();
    #1;
    n_total++;
    if (debug_rd_state !== 2'd0) $display("FAIL rst_fresh_done: got %0d exp 0", debug_rd_state);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read_s0();
    test_write_s1();
    test_read_decerr();
    test_write_decerr();
    test_concurrent_and_stall();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_addr_router.md
Name: axi_addr_router

Overview:
- 1-to-2 AXI4 address decoder/router: the downstream counterpart of the cache-side arbiter. It takes the single merged AXI master stream and routes each transaction to one of two AXI slaves (e.g. main memory, peripheral bus) by address.
- Read and write paths are independently locked per transaction.
- Unmapped addresses are absorbed by an internal error responder returning DECERR.

Parameters:
- S0_BASE, 32'h0000_0000, base address of slave 0 region
- S0_MASK, 32'hF000_0000, address bits compared for slave 0
- S1_BASE, 32'h1000_0000, base address of slave 1 region
- S1_MASK, 32'hF000_0000, address bits compared for slave 1

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- s_axi  axi_if.slave  interface  upstream AXI4 port (from the request arbiter)
- m_axi_0  axi_if.master  interface  downstream AXI4 port to slave 0
- m_axi_1  axi_if.master  interface  downstream AXI4 port to slave 1
- debug_rd_state  output  2  current read FSM state
- debug_wr_state  output  2  current write FSM state

Behaviour:
- Decode: sel0 = ((addr & S0_MASK) == S0_BASE); sel1 = !sel0 && ((addr & S1_MASK) == S1_BASE); otherwise decode error. Slave 0 wins on overlap.
- Unrouted or idle downstream ports get all master-driven outputs (valids, readies, payload) at 0. Unused upstream response fields are also driven 0.
- Reset: both FSMs IDLE, latched target/id/len cleared, every valid/ready output 0.
- A reset mid-transaction aborts it; downstream slaves are reset by the same rst_n.
- Read FSM states: R_IDLE, R_DATA, R_ERR.
  - R_IDLE: decode s_axi.araddr combinationally. AR is forwarded to the selected slave with zero latency; s_axi.arready = selected arready.
    - On AR handshake: latch target, go R_DATA.
    - On decode error: s_axi.arready=1; on handshake latch arid and arlen, beat counter=0, go R_ERR.
  - R_DATA: s_axi.arready=0. The R channel is passed through from the latched target.
    - On rvalid & rready & rlast: R_IDLE.
  - R_ERR: rvalid=1, rresp=2'b11, rdata=0, rid=latched arid, rlast=(count==latched arlen).
    - Count increments per handshake.
    - After the last handshake: R_IDLE.
- Write FSM states: W_IDLE, W_DATA, W_RESP, W_ERR.
  - W_IDLE: wready=0 upstream. AW decoded and forwarded as for AR.
    - On handshake: latch target, go W_DATA.
    - On decode error: awready=1, latch awid, go W_ERR.
  - W_DATA: W channel passed through to the latched target.
    - On wvalid & wready & wlast: W_RESP.
  - W_RESP: B channel passed through from the latched target.
    - On bvalid & bready: W_IDLE.
  - W_ERR has two phases, tracked by an internal flag:
    - Phase 1: sink W beats with wready=1 until the wlast handshake.
    - Phase 2: bvalid=1, bresp=2'b11, bid=latched awid; on bready: W_IDLE.
- Outstanding limits: one read and one write may be outstanding at the same time, to the same or different slaves. No second AR/AW is accepted until the current one completes.
- Payload pass-through is unmodified: id, addr, len, size, burst, data, strb, resp, last.
- No added latency on any forwarded channel. The only state-dependent gating is the latched target.
- Simultaneous AR and AW to different slaves both proceed in the same cycle.
- Upstream AR/AW valid held while the FSM is busy: it stays stalled (ready=0) and the payload is not sampled.

Test Plan:
1. Read burst araddr=32'h0000_0100, arlen=3, arid=2: AR appears only on m_axi_0 in the same cycle; 4 beats returned with rid=2; rlast on beat 4; m_axi_1 stays all-zero.
2. Single write awaddr=32'h1000_0004, wdata=32'hDEAD_BEEF, wstrb=4'hF: AW, W and B are routed via m_axi_1; upstream sees bresp=0; FSM back in W_IDLE the cycle after the B handshake.
3. Read araddr=32'h8000_0000, arlen=1, arid=5: neither downstream arvalid rises; 2 beats with rresp=2'b11, rdata=0, rid=5, rlast on the 2nd beat.
4. Write awaddr=32'h8000_0000, 3 W beats: all beats accepted with wready=1; then bresp=2'b11, bid=awid; downstream ports see nothing.
5. Concurrent AR to 32'h0000_0000 and AW to 32'h1000_0000 in the same cycle: both handshake that cycle to their respective slaves and complete independently. A second AR issued during R_DATA is held with arready=0 until rlast.
6. rst_n asserted during the beat 2 of 4 of a slave-0 read: next cycle both FSMs are IDLE and all valid/ready outputs are 0. A fresh read after reset completes normally.
